// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Purpose  : Execute stage. Single-cycle ALU/shift ops plus, when EX_MULDIV_EN
//            is defined, iterative 32-step unsigned multu/divu with HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage
`ifdef EX_MULDIV_EN
#(
   parameter int MD_ITER = 32
)
`endif
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_valid,
   input  logic [2:0]  i_ctrl_alu,
   input  logic        i_bse,
   input  logic [5:0]  i_funct,
   input  logic [4:0]  i_shift_amt,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [31:0] i_se,
   input  logic [4:0]  i_rd,
   input  logic [2:0]  i_ctrl_mux,
   output logic        o_busy,
   output logic        o_valid,
   output logic [31:0] o_result,
   output logic [31:0] o_store_data,
   output logic [4:0]  o_rd,
   output logic [2:0]  o_ctrl_mux,
   output logic        o_zero
);

   logic [31:0] w_b;
   logic [31:0] w_alu;
   logic        w_accept;

   logic        r_valid;
   logic [31:0] r_result;
   logic [31:0] r_store_data;
   logic [4:0]  r_rd;
   logic [2:0]  r_ctrl_mux;
   logic        r_zero;

`ifdef EX_MULDIV_EN
   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_MD_RUN = 1'b1
   } state_t;

   localparam logic [4:0] c_md_last = 5'(MD_ITER - 1);

   state_t      r_state;
   state_t      w_state_next;
   logic        w_md_start;
   logic        w_md_div;
   logic        w_md_last;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   // Working pair: multu = {partial product, multiplier}, divu = {remainder, quotient}
   logic [31:0] r_md_hi;
   logic [31:0] r_md_lo;
   logic [31:0] r_md_b;
   logic        r_md_div;
   logic [4:0]  r_md_cnt;
   logic [4:0]  r_md_rd;
   logic [1:0]  r_md_ctrl;
   logic [32:0] w_add;
   logic [32:0] w_rsh;
   logic [32:0] w_diff;
   logic [31:0] w_step_hi;
   logic [31:0] w_step_lo;

   assign w_accept  = i_valid && (r_state == S_IDLE);
   assign o_busy    = (r_state == S_MD_RUN);
   assign w_md_last = (r_state == S_MD_RUN) && (r_md_cnt == c_md_last);
`else
   assign w_accept  = i_valid;
   assign o_busy    = 1'b0;
`endif

   assign w_b = i_bse ? i_se : i_b;

   always_comb begin
      w_alu = 32'd0;
`ifdef EX_MULDIV_EN
      w_md_start = 1'b0;
      w_md_div   = 1'b0;
`endif
      case (i_ctrl_alu)
         3'b000: w_alu = i_a + w_b;
         3'b001: w_alu = i_a - w_b;
         3'b010: w_alu = i_a & w_b;
         3'b011: w_alu = i_a | w_b;
         3'b100: w_alu = {31'd0, ($signed(i_a) < $signed(w_b))};
         3'b101: w_alu = {i_se[15:0], 16'h0000};
         3'b110: begin
            case (i_funct)
               6'h20: w_alu = i_a + w_b;
               6'h22: w_alu = i_a - w_b;
               6'h24: w_alu = i_a & w_b;
               6'h25: w_alu = i_a | w_b;
               6'h26: w_alu = i_a ^ w_b;
               6'h27: w_alu = ~(i_a | w_b);
               6'h2A: w_alu = {31'd0, ($signed(i_a) < $signed(w_b))};
               6'h00: w_alu = i_b << i_shift_amt;
               6'h02: w_alu = i_b >> i_shift_amt;
               6'h03: w_alu = $unsigned($signed(i_b) >>> i_shift_amt);
`ifdef EX_MULDIV_EN
               6'h10: w_alu = r_hi;
               6'h12: w_alu = r_lo;
               6'h19: w_md_start = 1'b1;
               6'h1B: begin
                  w_md_start = 1'b1;
                  w_md_div   = 1'b1;
               end
`endif
               default: w_alu = 32'd0;
            endcase
         end
         default: w_alu = 32'd0;
      endcase
   end

`ifdef EX_MULDIV_EN
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept && w_md_start) w_state_next = S_MD_RUN;
         S_MD_RUN: if (w_md_last) w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // One shift-add (multu) or restoring-subtract (divu) step per cycle
   always_comb begin
      w_add  = {1'b0, r_md_hi} + (r_md_lo[0] ? {1'b0, r_md_b} : 33'd0);
      w_rsh  = {r_md_hi, r_md_lo[31]};
      w_diff = w_rsh - {1'b0, r_md_b};
      if (r_md_div) begin
         if (!w_diff[32]) begin
            w_step_hi = w_diff[31:0];
            w_step_lo = {r_md_lo[30:0], 1'b1};
         end else begin
            w_step_hi = w_rsh[31:0];
            w_step_lo = {r_md_lo[30:0], 1'b0};
         end
      end else begin
         w_step_hi = w_add[32:1];
         w_step_lo = {w_add[0], r_md_lo[31:1]};
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid      <= 1'b0;
         r_result     <= 32'd0;
         r_store_data <= 32'd0;
         r_rd         <= 5'd0;
         r_ctrl_mux   <= 3'd0;
         r_zero       <= 1'b0;
`ifdef EX_MULDIV_EN
         r_hi         <= 32'd0;
         r_lo         <= 32'd0;
         r_md_hi      <= 32'd0;
         r_md_lo      <= 32'd0;
         r_md_b       <= 32'd0;
         r_md_div     <= 1'b0;
         r_md_cnt     <= 5'd0;
         r_md_rd      <= 5'd0;
         r_md_ctrl    <= 2'd0;
`endif
      end else begin
         r_valid <= 1'b0;
         if (w_accept) begin
            r_store_data <= i_b;
`ifdef EX_MULDIV_EN
            if (w_md_start) begin
               r_md_hi   <= 32'd0;
               r_md_lo   <= i_a;
               r_md_b    <= w_b;
               r_md_div  <= w_md_div;
               r_md_cnt  <= 5'd0;
               r_md_rd   <= i_rd;
               r_md_ctrl <= i_ctrl_mux[2:1];
            end else begin
`else
            begin
`endif
               r_valid    <= 1'b1;
               r_result   <= w_alu;
               r_zero     <= (w_alu == 32'd0);
               r_rd       <= i_rd;
               r_ctrl_mux <= i_ctrl_mux;
            end
         end
`ifdef EX_MULDIV_EN
         else if (r_state == S_MD_RUN) begin
            r_md_hi  <= w_step_hi;
            r_md_lo  <= w_step_lo;
            r_md_cnt <= r_md_cnt + 5'd1;
            // Final step commits HI/LO and retires with register write suppressed
            if (w_md_last) begin
               r_hi       <= w_step_hi;
               r_lo       <= w_step_lo;
               r_valid    <= 1'b1;
               r_result   <= w_step_lo;
               r_zero     <= (w_step_lo == 32'd0);
               r_rd       <= r_md_rd;
               r_ctrl_mux <= {r_md_ctrl, 1'b0};
            end
         end
`endif
      end
   end

   assign o_valid      = r_valid;
   assign o_result     = r_result;
   assign o_store_data = r_store_data;
   assign o_rd         = r_rd;
   assign o_ctrl_mux   = r_ctrl_mux;
   assign o_zero       = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// Testbench for ex_stage: directed vector table, multicycle sequences and
// random operations checked against an arithmetic reference model.
module tb_ex_stage;

`ifdef EX_MULDIV_EN
   localparam bit c_md_en = 1'b1;
`else
   localparam bit c_md_en = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_valid = 1'b0;
   logic [2:0]  i_ctrl_alu = '0;
   logic        i_bse = 1'b0;
   logic [5:0]  i_funct = '0;
   logic [4:0]  i_shift_amt = '0;
   logic [31:0] i_a = '0;
   logic [31:0] i_b = '0;
   logic [31:0] i_se = '0;
   logic [4:0]  i_rd = '0;
   logic [2:0]  i_ctrl_mux = '0;
   logic        o_busy;
   logic        o_valid;
   logic [31:0] o_result;
   logic [31:0] o_store_data;
   logic [4:0]  o_rd;
   logic [2:0]  o_ctrl_mux;
   logic        o_zero;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk          (clk),
      .rst          (rst),
      .i_valid      (i_valid),
      .i_ctrl_alu   (i_ctrl_alu),
      .i_bse        (i_bse),
      .i_funct      (i_funct),
      .i_shift_amt  (i_shift_amt),
      .i_a          (i_a),
      .i_b          (i_b),
      .i_se         (i_se),
      .i_rd         (i_rd),
      .i_ctrl_mux   (i_ctrl_mux),
      .o_busy       (o_busy),
      .o_valid      (o_valid),
      .o_result     (o_result),
      .o_store_data (o_store_data),
      .o_rd         (o_rd),
      .o_ctrl_mux   (o_ctrl_mux),
      .o_zero       (o_zero)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   typedef struct {
      logic [2:0]  ctrl;
      logic        bse;
      logic [5:0]  fn;
      logic [4:0]  sh;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] se;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[$];
   logic [5:0] fns [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic addv(input logic [2:0] ctrl, input logic bse, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] se, input logic [31:0] exp);
      vec_t v;
      v.ctrl = ctrl; v.bse = bse; v.fn = fn; v.sh = sh;
      v.a = a; v.b = b; v.se = se; v.exp = exp;
      tbl.push_back(v);
   endtask

   // Reference model: plain arithmetic on the architectural rules
   function automatic logic [31:0] ref_alu(input logic [2:0] ctrl, input logic bse, input logic [5:0] fn,
                                           input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] se);
      logic [31:0] bb;
      longint      sb;
      longint      ub;
      bb = bse ? se : b;
      sb = longint'(int'(b));
      ub = longint'({32'd0, b});
      case (ctrl)
         3'd0: return a + bb;
         3'd1: return a - bb;
         3'd2: return a & bb;
         3'd3: return a | bb;
         3'd4: return (int'(a) < int'(bb)) ? 32'd1 : 32'd0;
         3'd5: return {se[15:0], 16'h0000};
         3'd6: begin
            case (fn)
               6'h20: return a + bb;
               6'h22: return a - bb;
               6'h24: return a & bb;
               6'h25: return a | bb;
               6'h26: return a ^ bb;
               6'h27: return ~(a | bb);
               6'h2A: return (int'(a) < int'(bb)) ? 32'd1 : 32'd0;
               6'h00: return 32'(ub * (longint'(1) << sh));
               6'h02: return 32'(ub / (longint'(1) << sh));
               6'h03: return 32'(sb >>> sh);
               6'h10: return c_md_en ? m_hi : 32'd0;
               6'h12: return c_md_en ? m_lo : 32'd0;
               default: return 32'd0;
            endcase
         end
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic drive(input logic [2:0] ctrl, input logic bse, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] se,
                        input logic [4:0] rd, input logic [2:0] cm);
      i_ctrl_alu = ctrl; i_bse = bse; i_funct = fn; i_shift_amt = sh;
      i_a = a; i_b = b; i_se = se; i_rd = rd; i_ctrl_mux = cm;
   endtask

   task automatic run_single(input string tag, input logic [2:0] ctrl, input logic bse, input logic [5:0] fn,
                             input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] se, input logic [31:0] exp, input logic [4:0] rd,
                             input logic [2:0] cm);
      drive(ctrl, bse, fn, sh, a, b, se, rd, cm);
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      check({tag, ".valid"},  32'(o_valid), 32'd1);
      check({tag, ".result"}, o_result, exp);
      check({tag, ".zero"},   32'(o_zero), 32'(exp == 32'd0));
      check({tag, ".rd"},     32'(o_rd), 32'(rd));
      check({tag, ".ctrl"},   32'(o_ctrl_mux), 32'(cm));
      check({tag, ".store"},  o_store_data, b);
      check({tag, ".busy"},   32'(o_busy), 32'd0);
      @(posedge clk); #1;
      check({tag, ".pulse_end"}, 32'(o_valid), 32'd0);
      check({tag, ".hold"},      o_result, exp);
   endtask

`ifdef EX_MULDIV_EN
   task automatic run_md(input string tag, input logic div, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [2:0] cm, input bit poke);
      logic [63:0] p;
      logic [31:0] eh, el;
      int cyc;
      if (div) begin
         if (b == 32'd0) begin el = 32'hFFFF_FFFF; eh = a; end
         else begin el = a / b; eh = a % b; end
      end else begin
         p  = {32'd0, a} * {32'd0, b};
         eh = p[63:32];
         el = p[31:0];
      end
      drive(3'b110, 1'b0, div ? 6'h1B : 6'h19, 5'd0, a, b, 32'd0, rd, cm);
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      check({tag, ".busy_start"},  32'(o_busy), 32'd1);
      check({tag, ".valid_start"}, 32'(o_valid), 32'd0);
      cyc = 0;
      while (!o_valid && cyc < 40) begin
         if (poke && cyc == 3) begin
            drive(3'b000, 1'b0, 6'h00, 5'd0, 32'd1, 32'h5555_0000, 32'd0, 5'h1F, 3'b001);
            i_valid = 1'b1;
         end else begin
            i_valid = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      i_valid = 1'b0;
      check({tag, ".cycles"}, 32'(cyc), 32'd32);
      check({tag, ".result"}, o_result, el);
      check({tag, ".busy_end"}, 32'(o_busy), 32'd0);
      check({tag, ".rd"},     32'(o_rd), 32'(rd));
      check({tag, ".ctrl"},   32'(o_ctrl_mux), 32'({cm[2:1], 1'b0}));
      check({tag, ".zero"},   32'(o_zero), 32'(el == 32'd0));
      check({tag, ".store"},  o_store_data, b);
      m_hi = eh;
      m_lo = el;
      @(posedge clk); #1;
      check({tag, ".no_queue"}, 32'(o_valid), 32'd0);
   endtask
`endif

   initial begin
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00,
              6'h02, 6'h03, 6'h10, 6'h12, 6'h19, 6'h1B, 6'h3F, 6'h01};

      addv(3'd6, 1'b0, 6'h20, 5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'd0,        32'h8000_0000);
      addv(3'd6, 1'b0, 6'h03, 5'd4,  32'd0,         32'hF000_0000, 32'd0,        32'hFF00_0000);
      addv(3'd6, 1'b0, 6'h02, 5'd4,  32'd0,         32'hF000_0000, 32'd0,        32'h0F00_0000);
      addv(3'd5, 1'b1, 6'h00, 5'd0,  32'h9999_9999, 32'd0,         32'h0000_1234, 32'h1234_0000);
      addv(3'd1, 1'b1, 6'h00, 5'd0,  32'd5,         32'd9,         32'd5,        32'h0000_0000);
      addv(3'd0, 1'b1, 6'h00, 5'd0,  32'hFFFF_FFFF, 32'd7,         32'd1,        32'h0000_0000);
      addv(3'd0, 1'b0, 6'h00, 5'd0,  32'd1,         32'd2,         32'd100,      32'h0000_0003);
      addv(3'd2, 1'b0, 6'h00, 5'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0,        32'hF000_F000);
      addv(3'd3, 1'b0, 6'h00, 5'd0,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'd0,        32'hFFFF_F0F0);
      addv(3'd4, 1'b0, 6'h00, 5'd0,  32'h8000_0000, 32'd1,         32'd0,        32'h0000_0001);
      addv(3'd4, 1'b0, 6'h00, 5'd0,  32'd1,         32'h8000_0000, 32'd0,        32'h0000_0000);
      addv(3'd7, 1'b0, 6'h20, 5'd0,  32'd1,         32'd2,         32'd0,        32'h0000_0000);
      addv(3'd6, 1'b0, 6'h22, 5'd0,  32'd0,         32'd1,         32'd0,        32'hFFFF_FFFF);
      addv(3'd6, 1'b0, 6'h26, 5'd0,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0,        32'hF0F0_0F0F);
      addv(3'd6, 1'b0, 6'h27, 5'd0,  32'hF000_0000, 32'h0000_000F, 32'd0,        32'h0FFF_FFF0);
      addv(3'd6, 1'b0, 6'h2A, 5'd0,  32'hFFFF_FFFF, 32'd0,         32'd0,        32'h0000_0001);
      addv(3'd6, 1'b0, 6'h00, 5'd31, 32'd0,         32'd3,         32'd0,        32'h8000_0000);
      addv(3'd6, 1'b0, 6'h03, 5'd0,  32'd0,         32'h8000_0001, 32'd0,        32'h8000_0001);
      addv(3'd6, 1'b0, 6'h3F, 5'd0,  32'd5,         32'd6,         32'd0,        32'h0000_0000);
      addv(3'd6, 1'b0, 6'h24, 5'd0,  32'h1234_5678, 32'h0000_FFFF, 32'd0,        32'h0000_5678);
      addv(3'd6, 1'b0, 6'h25, 5'd0,  32'd0,         32'd0,         32'd0,        32'h0000_0000);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst.valid",  32'(o_valid), 32'd0);
      check("rst.busy",   32'(o_busy), 32'd0);
      check("rst.result", o_result, 32'd0);
      check("rst.store",  o_store_data, 32'd0);
      check("rst.rd",     32'(o_rd), 32'd0);
      check("rst.ctrl",   32'(o_ctrl_mux), 32'd0);

      foreach (tbl[i])
         run_single($sformatf("vec%0d", i), tbl[i].ctrl, tbl[i].bse, tbl[i].fn, tbl[i].sh,
                    tbl[i].a, tbl[i].b, tbl[i].se, tbl[i].exp, 5'(i + 1), 3'(i));

`ifdef EX_MULDIV_EN
      run_md("multu_max", 1'b0, 32'hFFFF_FFFF, 32'd2, 5'd9, 3'b111, 1'b1);
      run_single("mfhi1", 3'd6, 1'b0, 6'h10, 5'd0, 32'd0, 32'd0, 32'd0, 32'h0000_0001, 5'd3, 3'b101);
      run_single("mflo1", 3'd6, 1'b0, 6'h12, 5'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFE, 5'd4, 3'b011);
      run_md("divu_by0", 1'b1, 32'h64, 32'd0, 5'd10, 3'b011, 1'b0);
      run_single("mflo2", 3'd6, 1'b0, 6'h12, 5'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 5'd5, 3'b001);
      run_single("mfhi2", 3'd6, 1'b0, 6'h10, 5'd0, 32'd0, 32'd0, 32'd0, 32'h0000_0064, 5'd6, 3'b001);
      run_md("divu_7", 1'b1, 32'h64, 32'd7, 5'd11, 3'b101, 1'b0);
      run_single("mflo3", 3'd6, 1'b0, 6'h12, 5'd0, 32'd0, 32'd0, 32'd0, 32'h0000_000E, 5'd7, 3'b001);
      run_single("mfhi3", 3'd6, 1'b0, 6'h10, 5'd0, 32'd0, 32'd0, 32'd0, 32'h0000_0002, 5'd8, 3'b001);

      // New accept on the same cycle the multiply retires
      begin
         int cyc;
         drive(3'b110, 1'b0, 6'h19, 5'd0, 32'd3, 32'd5, 32'd0, 5'd2, 3'b001);
         i_valid = 1'b1;
         @(posedge clk); #1;
         i_valid = 1'b0;
         cyc = 0;
         while (!o_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
         end
         check("b2b.md_result", o_result, 32'd15);
         drive(3'b000, 1'b0, 6'h00, 5'd0, 32'd1, 32'd1, 32'd0, 5'd12, 3'b001);
         i_valid = 1'b1;
         @(posedge clk); #1;
         i_valid = 1'b0;
         check("b2b.valid",  32'(o_valid), 32'd1);
         check("b2b.result", o_result, 32'd2);
         m_hi = 32'd0;
         m_lo = 32'd15;
      end

      // Reset in the 10th MD_RUN cycle aborts the operation
      begin
         int nv;
         drive(3'b110, 1'b0, 6'h19, 5'd0, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 5'd13, 3'b001);
         i_valid = 1'b1;
         @(posedge clk); #1;
         i_valid = 1'b0;
         repeat (9) begin
            @(posedge clk); #1;
         end
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         check("mdrst.busy",   32'(o_busy), 32'd0);
         check("mdrst.valid",  32'(o_valid), 32'd0);
         check("mdrst.result", o_result, 32'd0);
         nv = 0;
         repeat (40) begin
            @(posedge clk); #1;
            if (o_valid) nv++;
         end
         check("mdrst.no_valid", 32'(nv), 32'd0);
         m_hi = 32'd0;
         m_lo = 32'd0;
         run_single("mdrst.mfhi", 3'd6, 1'b0, 6'h10, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd1, 3'b001);
         run_single("mdrst.mflo", 3'd6, 1'b0, 6'h12, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd1, 3'b001);
      end
`else
      // Without the multiplier these functs are unknown: result 0, ctrl untouched
      run_single("nomd.mfhi",  3'd6, 1'b0, 6'h10, 5'd0, 32'd7, 32'd3, 32'd0, 32'd0, 5'd3, 3'b101);
      run_single("nomd.mflo",  3'd6, 1'b0, 6'h12, 5'd0, 32'd7, 32'd3, 32'd0, 32'd0, 5'd4, 3'b111);
      run_single("nomd.multu", 3'd6, 1'b0, 6'h19, 5'd0, 32'd7, 32'd3, 32'd0, 32'd0, 5'd5, 3'b111);
      run_single("nomd.divu",  3'd6, 1'b0, 6'h1B, 5'd0, 32'd7, 32'd3, 32'd0, 32'd0, 5'd6, 3'b011);
      drive(3'b000, 1'b0, 6'h00, 5'd0, 32'd40, 32'd2, 32'd0, 5'd21, 3'b111);
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst2.valid",  32'(o_valid), 32'd0);
      check("rst2.result", o_result, 32'd0);
      check("rst2.store",  o_store_data, 32'd0);
      check("rst2.rd",     32'(o_rd), 32'd0);
      check("rst2.ctrl",   32'(o_ctrl_mux), 32'd0);
`endif

      for (int i = 0; i < 300; i++) begin
         logic [2:0]  ctrl;
         logic        bse;
         logic [5:0]  fn;
         logic [4:0]  sh;
         logic [31:0] a, b, se;
         ctrl = 3'($urandom_range(0, 7));
         bse  = 1'($urandom_range(0, 1));
         fn   = fns[$urandom_range(0, 15)];
         sh   = 5'($urandom_range(0, 31));
         a    = pick32();
         b    = pick32();
         se   = pick32();
`ifdef EX_MULDIV_EN
         if (ctrl == 3'd6 && (fn == 6'h19 || fn == 6'h1B)) begin
            run_md("rnd_md", fn == 6'h1B, a, bse ? se : b, 5'($urandom), 3'($urandom), 1'b0);
            continue;
         end
`endif
         run_single("rnd", ctrl, bse, fn, sh, a, b, se, ref_alu(ctrl, bse, fn, sh, a, b, se),
                    5'($urandom), 3'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
